// File: rtl/int_controller.sv
// rtl/int_controller.sv - interrupt front end: sync, edge detect, pending, priority, pulse delivery
module int_controller #(
  parameter int NUM_SRC      = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               icti_clk,
  input  logic               icti_rst,
  input  logic [NUM_SRC-1:0] icti_src,
  input  logic [NUM_SRC-1:0] icti_mask,
  input  logic               icti_int_enable,
  input  logic               icti_int_disable,
  input  logic               icti_pause_request,
  input  logic               icti_eret,
  output logic               icto_hard_int,
  output logic [3:0]         icto_int_id,
  output logic [NUM_SRC-1:0] icto_pending,
  output logic               icto_in_service,
  output logic               icto_enabled
);

  localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FIRE, WAIT} state_t;

  logic [NUM_SRC-1:0]     sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0]     sync_d [SYNC_STAGES];
  logic [NUM_SRC-1:0]     dly_q, dly_d;
  logic [NUM_SRC-1:0]     armed_q, armed_d;
  logic [NUM_SRC-1:0]     pend_q, pend_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   en_q, en_d;

  state_t                 state_q, state_d;
  logic                   hard_q, hard_d;
  logic [3:0]             id_q, id_d;
  logic                   svc_q, svc_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [NUM_SRC-1:0]     last, rise, eligible, sel_oh, clr;
  logic [3:0]             sel_id;
  logic                   fire;

  // Synchronizer chain, edge detect, pending set/clear and global enable.
  // A source is only armed once its synchronized level has been seen low after
  // the chain refilled from reset, so a line held high across reset is not a request.
  always_comb begin
    sync_d[0] = icti_src;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    last    = sync_q[SYNC_STAGES-1];
    dly_d   = last;
    fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
    armed_d = armed_q | ({NUM_SRC{fill_q[SYNC_STAGES-1]}} & ~last);
    rise    = last & ~dly_q & armed_q;
    pend_d  = (pend_q & ~clr) | rise;
    en_d    = icti_int_disable ? 1'b0 : (icti_int_enable ? 1'b1 : en_q);
  end

  // Lowest-index eligible source wins.
  always_comb begin
    eligible = pend_q & ~icti_mask;
    sel_id   = 4'd0;
    sel_oh   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_id    = 4'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
    fire = (state_q == IDLE) && (|eligible) && en_q && !icti_pause_request;
    clr  = fire ? sel_oh : '0;
  end

  // Delivery FSM: pulse for PULSE_CYCLES, then hold off until ERET.
  always_comb begin
    state_d = state_q;
    hard_d  = hard_q;
    id_d    = id_q;
    svc_d   = svc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = FIRE;
          hard_d  = 1'b1;
          id_d    = sel_id;
          cnt_d   = CW'(PULSE_CYCLES - 1);
        end
      end
      FIRE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          hard_d  = 1'b0;
          svc_d   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (icti_eret) begin
          svc_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Front-end registers.
  always_ff @(posedge icti_clk) begin
    if (!icti_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      dly_q   <= '0;
      armed_q <= '0;
      pend_q  <= '0;
      fill_q  <= '0;
      en_q    <= 1'b1;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
      dly_q   <= dly_d;
      armed_q <= armed_d;
      pend_q  <= pend_d;
      fill_q  <= fill_d;
      en_q    <= en_d;
    end
  end

  // FSM state and its registered outputs.
  always_ff @(posedge icti_clk) begin
    if (!icti_rst) begin
      state_q <= IDLE;
      hard_q  <= 1'b0;
      id_q    <= 4'd0;
      svc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hard_q  <= hard_d;
      id_q    <= id_d;
      svc_q   <= svc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign icto_hard_int   = hard_q;
  assign icto_int_id     = id_q;
  assign icto_pending    = pend_q;
  assign icto_in_service = svc_q;
  assign icto_enabled    = en_q;

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - randomized bench for int_controller against a behavioural model
module tb_int_controller;
  localparam int NS = 4;
  localparam int PC = 2;
  localparam int SS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, dis, pause, eret;
  logic [NS-1:0] src, mask;
  logic          hard_int, in_service, enabled;
  logic [3:0]    int_id;
  logic [NS-1:0] pending;

  int_controller #(.NUM_SRC(NS), .PULSE_CYCLES(PC), .SYNC_STAGES(SS)) dut (
    .icti_clk(clk), .icti_rst(rst), .icti_src(src), .icti_mask(mask),
    .icti_int_enable(en), .icti_int_disable(dis), .icti_pause_request(pause),
    .icti_eret(eret), .icto_hard_int(hard_int), .icto_int_id(int_id),
    .icto_pending(pending), .icto_in_service(in_service), .icto_enabled(enabled)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference state: what the outputs must show after the most recent edge.
  logic [NS-1:0] m_pend;
  logic [3:0]    m_id;
  bit            m_hard, m_svc, m_en;
  int            m_left;
  logic [NS-1:0] hist[$];   // src value present before each edge since reset

  task automatic model_edge(input bit r, input logic [NS-1:0] s, input logic [NS-1:0] m,
                            input bit e, input bit d, input bit p, input bit er);
    logic [NS-1:0] rise, elig, clear;
    int t;
    if (!r) begin
      m_pend = '0; m_id = 4'd0; m_hard = 0; m_svc = 0; m_en = 1; m_left = 0;
      hist.delete();
      return;
    end
    hist.push_back(s);
    t = hist.size();
    // A request is a 0->1 step between two consecutive post-reset samples,
    // seen SS edges late and landing in pending one edge after that.
    rise = '0;
    if (t >= SS + 2) rise = hist[t-SS-1] & ~hist[t-SS-2];
    elig  = m_pend & ~m;
    clear = '0;
    if (m_hard) begin
      m_left--;
      if (m_left == 0) begin m_hard = 0; m_svc = 1; end
    end else if (m_svc) begin
      if (er) m_svc = 0;
    end else if (elig != '0 && m_en && !p) begin
      for (int i = 0; i < NS; i++) begin
        if (elig[i]) begin
          m_id = 4'(i); clear[i] = 1'b1; break;
        end
      end
      m_hard = 1; m_left = PC;
    end
    m_pend = (m_pend & ~clear) | rise;
    if (d) m_en = 0;
    else if (e) m_en = 1;
  endtask

  // One cycle: check state after the previous edge, then apply inputs for the next edge.
  task automatic step(input bit r, input logic [NS-1:0] s, input logic [NS-1:0] m,
                      input bit e, input bit d, input bit p, input bit er);
    @(negedge clk);
    if (chk_on) begin
      chk("hard_int",   32'(hard_int),   32'(m_hard));
      chk("int_id",     32'(int_id),     32'(m_id));
      chk("pending",    32'(pending),    32'(m_pend));
      chk("in_service", 32'(in_service), 32'(m_svc));
      chk("enabled",    32'(enabled),    32'(m_en));
    end
    rst = r; src = s; mask = m; en = e; dis = d; pause = p; eret = er;
    model_edge(r, s, m, e, d, p, er);
  endtask

  task automatic idle(input int n, input logic [NS-1:0] s, input logic [NS-1:0] m);
    for (int i = 0; i < n; i++) step(1, s, m, 0, 0, 0, 0);
  endtask

  int            cnt, width;
  logic [NS-1:0] rs, rm;

  initial begin
    rst = 0; src = '0; mask = '0; en = 0; dis = 0; pause = 0; eret = 0;
    step(0, '0, '0, 0, 0, 0, 0);
    chk_on = 1;
    step(0, '0, '0, 0, 0, 0, 0);
    idle(4, '0, '0);

    // Latency and pulse width for a single source.
    step(1, 4'b0100, '0, 0, 0, 0, 0);
    cnt = 0;
    while (hard_int !== 1'b1 && cnt < 20) begin step(1, 4'b0100, '0, 0, 0, 0, 0); cnt++; end
    chk("latency_edges", 32'(cnt), 32'd4);
    width = 0;
    while (hard_int === 1'b1 && width < 20) begin step(1, 4'b0100, '0, 0, 0, 0, 0); width++; end
    chk("pulse_width", 32'(width), 32'(PC));
    chk("id_after_pulse", 32'(int_id), 32'd2);
    idle(3, '0, '0);
    step(1, '0, '0, 0, 0, 0, 1);

    // Two simultaneous requests, ERET gates the second.
    step(1, 4'b1010, '0, 0, 0, 0, 0);
    idle(12, 4'b1010, '0);
    chk("second_held", 32'(pending[3]), 32'd1);
    step(1, '0, '0, 0, 0, 0, 1);
    idle(8, '0, '0);
    step(1, '0, '0, 0, 0, 0, 1);

    // Disable, request, re-enable; then both pulses together.
    step(1, '0, '0, 0, 1, 0, 0);
    step(1, 4'b0001, '0, 0, 0, 0, 0);
    idle(6, 4'b0001, '0);
    step(1, '0, '0, 1, 0, 0, 0);
    idle(6, '0, '0);
    step(1, '0, '0, 0, 0, 0, 1);
    step(1, '0, '0, 1, 1, 0, 0);
    idle(2, '0, '0);
    step(1, '0, '0, 1, 0, 0, 0);

    // Mask, pause-during-fire, then reset mid-pulse with a held source.
    step(1, 4'b0001, 4'b0001, 0, 0, 0, 0);
    idle(6, 4'b0001, 4'b0001);
    step(1, '0, '0, 0, 0, 0, 0);
    step(1, '0, '0, 0, 0, 1, 0);
    idle(3, '0, '0);
    step(1, '0, '0, 0, 0, 0, 1);
    step(1, 4'b0010, '0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 4'b0010, '0, 0, 0, 1, 0);
    step(1, 4'b0010, '0, 0, 0, 0, 0);
    step(1, 4'b0010, '0, 0, 0, 1, 0);
    step(0, 4'b0010, '0, 0, 0, 0, 0);
    idle(10, 4'b0010, '0);
    chk("held_no_retrigger", 32'(pending), 32'd0);
    idle(2, '0, '0);
    idle(6, 4'b0010, '0);

    // Randomized traffic.
    rs = '0; rm = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < NS; b++) if ($urandom_range(0, 5) == 0) rs[b] = ~rs[b];
      if ($urandom_range(0, 15) == 0) rm = NS'($urandom);
      step(($urandom_range(0, 299) != 0), rs, rm,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    step(1, '0, '0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
